// File: rtl/alu_pipe.sv
// Two-stage pipelined integer ALU: S1 captures the issued op, S2 computes and
// broadcasts the result on the common data bus exactly two edges after issue.
module alu_pipe #(
  parameter int XLEN           = 32,
  parameter int ROB_SIZE_WIDTH = 4,
  parameter int ALU_OP_WIDTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      rs_ready,
  input  logic [ALU_OP_WIDTH-1:0]   rs_op,
  input  logic [XLEN-1:0]           rs_val1,
  input  logic [XLEN-1:0]           rs_val2,
  input  logic [ROB_SIZE_WIDTH-1:0] rs_id,
  output logic                      alu_ready,
  output logic [XLEN-1:0]           alu_res,
  output logic [ROB_SIZE_WIDTH-1:0] alu_id,
  output logic                      alu_err,
  output logic [31:0]               alu_done_cnt
);

  localparam logic [ALU_OP_WIDTH-1:0] OP_NOP  = ALU_OP_WIDTH'(0);
  localparam logic [ALU_OP_WIDTH-1:0] OP_ADD  = ALU_OP_WIDTH'(1);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SUB  = ALU_OP_WIDTH'(2);
  localparam logic [ALU_OP_WIDTH-1:0] OP_AND  = ALU_OP_WIDTH'(3);
  localparam logic [ALU_OP_WIDTH-1:0] OP_OR   = ALU_OP_WIDTH'(4);
  localparam logic [ALU_OP_WIDTH-1:0] OP_XOR  = ALU_OP_WIDTH'(5);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SHL  = ALU_OP_WIDTH'(6);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SHR  = ALU_OP_WIDTH'(7);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SHRA = ALU_OP_WIDTH'(8);
  localparam logic [ALU_OP_WIDTH-1:0] OP_EQ   = ALU_OP_WIDTH'(9);
  localparam logic [ALU_OP_WIDTH-1:0] OP_NEQ  = ALU_OP_WIDTH'(10);
  localparam logic [ALU_OP_WIDTH-1:0] OP_LT   = ALU_OP_WIDTH'(11);
  localparam logic [ALU_OP_WIDTH-1:0] OP_LTU  = ALU_OP_WIDTH'(12);
  localparam logic [ALU_OP_WIDTH-1:0] OP_GE   = ALU_OP_WIDTH'(13);
  localparam logic [ALU_OP_WIDTH-1:0] OP_GEU  = ALU_OP_WIDTH'(14);

  logic                      s1_valid;
  logic [ALU_OP_WIDTH-1:0]   s1_op;
  logic [XLEN-1:0]           s1_val1;
  logic [XLEN-1:0]           s1_val2;
  logic [ROB_SIZE_WIDTH-1:0] s1_id;

  logic [XLEN-1:0] res_d;
  logic            err_d;
  logic [4:0]      shamt;
  logic            lt_s;
  logic            lt_u;

  // Operand registers only load on an accepted issue; s1_valid alone gates S2.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_val1  <= '0;
      s1_val2  <= '0;
      s1_id    <= '0;
    end else begin
      s1_valid <= rs_ready && !flush;
      if (rs_ready && !flush) begin
        s1_op   <= rs_op;
        s1_val1 <= rs_val1;
        s1_val2 <= rs_val2;
        s1_id   <= rs_id;
      end
    end
  end

  assign shamt = s1_val2[4:0];
  assign lt_s  = $signed(s1_val1) < $signed(s1_val2);
  assign lt_u  = s1_val1 < s1_val2;

  always_comb begin
    res_d = '0;
    err_d = 1'b0;
    case (s1_op)
      OP_NOP:  res_d = '0;
      OP_ADD:  res_d = s1_val1 + s1_val2;
      OP_SUB:  res_d = s1_val1 - s1_val2;
      OP_AND:  res_d = s1_val1 & s1_val2;
      OP_OR:   res_d = s1_val1 | s1_val2;
      OP_XOR:  res_d = s1_val1 ^ s1_val2;
      OP_SHL:  res_d = s1_val1 << shamt;
      OP_SHR:  res_d = s1_val1 >> shamt;
      OP_SHRA: res_d = $unsigned($signed(s1_val1) >>> shamt);
      OP_EQ:   res_d = XLEN'(s1_val1 == s1_val2);
      OP_NEQ:  res_d = XLEN'(s1_val1 != s1_val2);
      OP_LT:   res_d = XLEN'(lt_s);
      OP_LTU:  res_d = XLEN'(lt_u);
      OP_GE:   res_d = XLEN'(!lt_s);
      OP_GEU:  res_d = XLEN'(!lt_u);
      default: err_d = 1'b1;
    endcase
  end

  // A pulse already on the bus at a flush edge was sampled by consumers there;
  // only the op sitting in S1 is squashed.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_ready    <= 1'b0;
      alu_res      <= '0;
      alu_id       <= '0;
      alu_err      <= 1'b0;
      alu_done_cnt <= '0;
    end else if (flush) begin
      alu_ready <= 1'b0;
      alu_err   <= 1'b0;
    end else begin
      alu_ready <= s1_valid;
      if (s1_valid) begin
        alu_res      <= res_d;
        alu_id       <= s1_id;
        alu_err      <= err_d;
        alu_done_cnt <= alu_done_cnt + 32'd1;
      end else begin
        alu_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed-vector bench for alu_pipe: latency, throughput, op results, flush
// squash and mid-operation reset, all against hand-computed expectations.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        rs_ready;
  logic [3:0]  rs_op;
  logic [31:0] rs_val1;
  logic [31:0] rs_val2;
  logic [3:0]  rs_id;
  logic        alu_ready;
  logic [31:0] alu_res;
  logic [3:0]  alu_id;
  logic        alu_err;
  logic [31:0] alu_done_cnt;

  int errors = 0;
  int checks = 0;

  alu_pipe dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .rs_ready     (rs_ready),
    .rs_op        (rs_op),
    .rs_val1      (rs_val1),
    .rs_val2      (rs_val2),
    .rs_id        (rs_id),
    .alu_ready    (alu_ready),
    .alu_res      (alu_res),
    .alu_id       (alu_id),
    .alu_err      (alu_err),
    .alu_done_cnt (alu_done_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  id;
    logic [31:0] res;
    logic        err;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs[NVEC];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] id);
    rs_ready = 1'b1;
    rs_op    = op;
    rs_val1  = a;
    rs_val2  = b;
    rs_id    = id;
  endtask

  task automatic idle();
    rs_ready = 1'b0;
    rs_op    = 4'd0;
    rs_val1  = 32'h0;
    rs_val2  = 32'h0;
    rs_id    = 4'd0;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_ready"}, 32'(alu_ready), 32'd0);
    check_val({tag, "_res"},   alu_res, 32'd0);
    check_val({tag, "_id"},    32'(alu_id), 32'd0);
    check_val({tag, "_err"},   32'(alu_err), 32'd0);
    check_val({tag, "_cnt"},   alu_done_cnt, 32'd0);
  endtask

  initial begin
    logic [31:0] cnt_base;

    vecs[0]  = '{4'd2,  32'h00000000, 32'h00000001, 4'd1,  32'hFFFFFFFF, 1'b0};
    vecs[1]  = '{4'd8,  32'h80000000, 32'h00000024, 4'd2,  32'hF8000000, 1'b0};
    vecs[2]  = '{4'd12, 32'h00000001, 32'hFFFFFFFF, 4'd3,  32'h00000001, 1'b0};
    vecs[3]  = '{4'd11, 32'h00000001, 32'hFFFFFFFF, 4'd4,  32'h00000000, 1'b0};
    vecs[4]  = '{4'd14, 32'h00000003, 32'h00000003, 4'd5,  32'h00000001, 1'b0};
    vecs[5]  = '{4'd13, 32'h80000000, 32'h00000000, 4'd6,  32'h00000000, 1'b0};
    vecs[6]  = '{4'd15, 32'h0000000A, 32'h0000000B, 4'd7,  32'h00000000, 1'b1};
    vecs[7]  = '{4'd0,  32'h12345678, 32'h9ABCDEF0, 4'd8,  32'h00000000, 1'b0};
    vecs[8]  = '{4'd1,  32'hFFFFFFFF, 32'h00000002, 4'd9,  32'h00000001, 1'b0};
    vecs[9]  = '{4'd3,  32'hF0F0F0F0, 32'hFF00FF00, 4'd10, 32'hF000F000, 1'b0};
    vecs[10] = '{4'd4,  32'hF0F0F0F0, 32'h0F0F0000, 4'd11, 32'hFFFFF0F0, 1'b0};
    vecs[11] = '{4'd5,  32'hFFFF0000, 32'h0F0F0F0F, 4'd12, 32'hF0F00F0F, 1'b0};
    vecs[12] = '{4'd6,  32'h00000001, 32'h00000021, 4'd13, 32'h00000002, 1'b0};
    vecs[13] = '{4'd7,  32'h80000000, 32'h0000001F, 4'd14, 32'h00000001, 1'b0};
    vecs[14] = '{4'd9,  32'h00000005, 32'h00000005, 4'd15, 32'h00000001, 1'b0};
    vecs[15] = '{4'd10, 32'h00000005, 32'h00000005, 4'd0,  32'h00000000, 1'b0};

    rst   = 1'b1;
    flush = 1'b0;
    idle();
    tick();
    tick();
    rst = 1'b0;
    check_all_zero("reset");

    // Single ADD: visible only after the second edge.
    issue(4'd1, 32'd5, 32'd7, 4'd3);
    tick();
    idle();
    check_val("add_lat_e1_ready", 32'(alu_ready), 32'd0);
    tick();
    check_val("add_ready", 32'(alu_ready), 32'd1);
    check_val("add_res",   alu_res, 32'd12);
    check_val("add_id",    32'(alu_id), 32'd3);
    check_val("add_err",   32'(alu_err), 32'd0);
    check_val("add_cnt",   alu_done_cnt, 32'd1);
    tick();
    check_val("add_drop_ready", 32'(alu_ready), 32'd0);
    check_val("add_hold_res",   alu_res, 32'd12);
    check_val("add_hold_id",    32'(alu_id), 32'd3);

    // Back-to-back table, one issue per cycle, results in issue order.
    for (int i = 0; i <= NVEC; i++) begin
      if (i < NVEC) issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].id);
      else idle();
      tick();
      if (i >= 1) begin
        check_val($sformatf("v%0d_ready", i - 1), 32'(alu_ready), 32'd1);
        check_val($sformatf("v%0d_res", i - 1),   alu_res, vecs[i - 1].res);
        check_val($sformatf("v%0d_id", i - 1),    32'(alu_id), 32'(vecs[i - 1].id));
        check_val($sformatf("v%0d_err", i - 1),   32'(alu_err), 32'(vecs[i - 1].err));
      end
    end
    idle();
    tick();
    check_val("table_drop_ready", 32'(alu_ready), 32'd0);
    check_val("table_cnt", alu_done_cnt, 32'(1 + NVEC));

    // Flush: id 5 on the bus completes, id 6 in S1 and id 9 at the flush edge are squashed.
    cnt_base = 32'(1 + NVEC);
    issue(4'd1, 32'd1, 32'd1, 4'd5);
    tick();
    issue(4'd1, 32'd2, 32'd2, 4'd6);
    tick();
    check_val("fl_id5_ready", 32'(alu_ready), 32'd1);
    check_val("fl_id5_res",   alu_res, 32'd2);
    check_val("fl_id5_id",    32'(alu_id), 32'd5);
    issue(4'd5, 32'hAAAA, 32'h5555, 4'd9);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    check_val("fl_edge_ready", 32'(alu_ready), 32'd0);
    check_val("fl_edge_cnt",   alu_done_cnt, cnt_base + 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_val($sformatf("fl_quiet%0d_ready", k), 32'(alu_ready), 32'd0);
    end
    check_val("fl_hold_id",  32'(alu_id), 32'd5);
    check_val("fl_hold_res", alu_res, 32'd2);
    check_val("fl_cnt",      alu_done_cnt, cnt_base + 32'd1);

    // Issue right after flush deasserts is accepted normally.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    issue(4'd1, 32'd3, 32'd4, 4'd10);
    tick();
    idle();
    tick();
    check_val("post_fl_ready", 32'(alu_ready), 32'd1);
    check_val("post_fl_res",   alu_res, 32'd7);
    check_val("post_fl_id",    32'(alu_id), 32'd10);
    check_val("post_fl_cnt",   alu_done_cnt, cnt_base + 32'd2);
    tick();

    // Reset one cycle after the first of three issues kills everything.
    issue(4'd1, 32'd10, 32'd20, 4'd1);
    tick();
    issue(4'd1, 32'd30, 32'd40, 4'd2);
    rst = 1'b1;
    tick();
    check_all_zero("mid_rst");
    issue(4'd1, 32'd50, 32'd60, 4'd3);
    tick();
    rst = 1'b0;
    idle();
    for (int k = 0; k < 4; k++) begin
      tick();
      check_val($sformatf("rst_quiet%0d_ready", k), 32'(alu_ready), 32'd0);
    end
    check_all_zero("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
